fig_ring_gen: RTL and testbench

- Parametrised successor to the single-ring figure generator.
- Accepts a centre point (x, y, hue, radius) over a req/ack handshake.
- Emits the pixels of RINGS concentric midpoint circles (radius r, r+1, …), with value fading per ring, to the pixel sink over a stallable req/ack stream.
- Sits between the Lissajous point source and the HSV framebuffer writer; points outside the screen are clipped internally.

---
 rtl/fig_pkg.sv | 48 ++++
 rtl/fig_circle_step.sv | 57 +++++
 rtl/fig_ring_gen.sv | 165 ++++++++++++++++
 tb/tb_fig_ring_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fig_pkg.sv
// Shared types and helpers for the concentric-ring figure generator.
package fig_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    EMIT,
    STEP,
    NEXT_RING,
    DONE
  } fig_state_t;

  // Octant slot offsets: (cx,cy),(cy,cx),(-cy,cx),(-cx,cy),(-cx,-cy),(-cy,-cx),(cy,-cx),(cx,-cy)
  function automatic int slot_dx(input logic [2:0] s, input int cx, input int cy);
    case (s)
      3'd0: return cx;
      3'd1: return cy;
      3'd2: return -cy;
      3'd3: return -cx;
      3'd4: return -cx;
      3'd5: return -cy;
      3'd6: return cy;
      default: return cx;
    endcase
  endfunction

  function automatic int slot_dy(input logic [2:0] s, input int cx, input int cy);
    case (s)
      3'd0: return cy;
      3'd1: return cx;
      3'd2: return cx;
      3'd3: return cy;
      3'd4: return -cy;
      3'd5: return -cx;
      3'd6: return -cx;
      default: return -cy;
    endcase
  endfunction

  function automatic logic [7:0] fade_v(input int k, input int v_step);
    int v;
    v = 255 - k * v_step;
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

endpackage

// File: rtl/fig_circle_step.sv
// Midpoint circle stepper: holds cx, cy and the decision variable d for one ring.
module fig_circle_step #(
  parameter int RW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic [RW-1:0] rad,
  output logic [RW:0]   cx,
  output logic [RW:0]   cy,
  output logic          done,
  output logic          on_axis,
  output logic          on_diag
);

  localparam logic signed [RW+2:0] ONE = 1;

  logic signed [RW+2:0] d;
  logic signed [RW+2:0] d_inc;
  logic signed [RW+2:0] cyn_s;
  logic signed [RW+2:0] cxn_s;
  logic [RW:0]          cy_n;
  logic [RW:0]          cx_n;
  logic                 d_neg;

  // done looks ahead at the post-step values so STEP can branch in its own cycle
  always_comb begin
    d_neg   = d[RW+2];
    cy_n    = cy + 1'b1;
    cx_n    = d_neg ? cx : cx - 1'b1;
    cyn_s   = $signed({2'b00, cy_n});
    cxn_s   = $signed({2'b00, cx_n});
    d_inc   = d_neg ? (cyn_s + cyn_s + ONE)
                    : ((cyn_s - cxn_s) + (cyn_s - cxn_s) + ONE);
    done    = cy_n > cx_n;
    on_axis = (cy == '0);
    on_diag = (cx == cy);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cx <= '0;
      cy <= '0;
      d  <= '0;
    end else if (load) begin
      cx <= {1'b0, rad};
      cy <= '0;
      d  <= ONE - $signed({3'b000, rad});
    end else if (step) begin
      cx <= cx_n;
      cy <= cy_n;
      d  <= d + d_inc;
    end
  end

endmodule

// File: rtl/fig_ring_gen.sv
// Concentric midpoint-circle figure generator with per-ring fade and screen clipping.
module fig_ring_gen
  import fig_pkg::*;
#(
  parameter int XW     = 8,
  parameter int YW     = 9,
  parameter int RW     = 5,
  parameter int X_MAX  = 255,
  parameter int Y_MAX  = 319,
  parameter int RINGS  = 3,
  parameter int V_STEP = 64,
  parameter int SAT    = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [XW-1:0] pt_x,
  input  logic [YW-1:0] pt_y,
  input  logic [7:0]    pt_h,
  input  logic [RW-1:0] pt_r,
  input  logic          pt_req_i,
  output logic          pt_ack_o,
  output logic [XW-1:0] fig_x_o,
  output logic [YW-1:0] fig_y_o,
  output logic [7:0]    fig_h_o,
  output logic [7:0]    fig_s_o,
  output logic [7:0]    fig_v_o,
  output logic          fig_req_o,
  input  logic          fig_ack_i,
  output logic          busy_o
);

  localparam int PW = ((XW > YW) ? XW : YW) + 2;
  localparam logic signed [PW-1:0] X_LIM = PW'(X_MAX);
  localparam logic signed [PW-1:0] Y_LIM = PW'(Y_MAX);

  fig_state_t state, state_next;

  logic [XW-1:0] cap_x;
  logic [YW-1:0] cap_y;
  logic [7:0]    cap_h;
  logic [RW-1:0] cap_r;
  logic [2:0]    ring;
  logic [7:0]    ring_v;
  logic [2:0]    slot;
  logic [RW:0]   cx, cy, rad_sum;
  logic          step_done, on_axis, on_diag;
  logic          ld, stp, issue, accept;
  logic          sparse, center, slot_last, can_issue, visible;
  logic signed [PW-1:0] dx, dy, px, py;

  assign rad_sum = {1'b0, cap_r} + (RW+1)'(ring);
  assign busy_o  = (state != IDLE);

  fig_circle_step #(.RW(RW)) u_step (
    .clock   (clock),
    .reset   (reset),
    .load    (ld),
    .step    (stp),
    .rad     (rad_sum[RW-1:0]),
    .cx      (cx),
    .cy      (cy),
    .done    (step_done),
    .on_axis (on_axis),
    .on_diag (on_diag)
  );

  always_comb begin
    sparse    = on_axis | on_diag;
    center    = (cx == '0);
    if (center)      slot_last = (slot == 3'd0);
    else if (sparse) slot_last = (slot == 3'd6);
    else             slot_last = (slot == 3'd7);
    can_issue = !fig_req_o || fig_ack_i;
    accept    = (state == IDLE) && !pt_ack_o && pt_req_i;
    dx        = PW'(slot_dx(slot, int'(cx), int'(cy)));
    dy        = PW'(slot_dy(slot, int'(cx), int'(cy)));
    px        = $signed(PW'(cap_x)) + dx;
    py        = $signed(PW'(cap_y)) + dy;
    visible   = !px[PW-1] && (px <= X_LIM) && !py[PW-1] && (py <= Y_LIM);
  end

  // Transitions into DONE wait for the last pixel to drain so DONE always shows fig_req_o=0
  always_comb begin
    state_next = state;
    ld         = 1'b0;
    stp        = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE:      if (pt_ack_o) state_next = INIT;
      INIT: begin
        if (rad_sum[RW]) begin
          if (can_issue) state_next = DONE;
        end else begin
          ld         = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (can_issue) begin
          issue = 1'b1;
          if (slot_last) state_next = center ? NEXT_RING : STEP;
        end
      end
      STEP: begin
        stp        = 1'b1;
        state_next = step_done ? NEXT_RING : EMIT;
      end
      NEXT_RING: begin
        if (int'(ring) + 1 < RINGS) state_next = INIT;
        else if (can_issue)         state_next = DONE;
      end
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      pt_ack_o  <= 1'b0;
      cap_x     <= '0;
      cap_y     <= '0;
      cap_h     <= '0;
      cap_r     <= '0;
      ring      <= '0;
      ring_v    <= '0;
      slot      <= '0;
      fig_x_o   <= '0;
      fig_y_o   <= '0;
      fig_h_o   <= '0;
      fig_s_o   <= '0;
      fig_v_o   <= '0;
      fig_req_o <= 1'b0;
    end else begin
      state    <= state_next;
      pt_ack_o <= accept;
      if (accept) begin
        cap_x <= pt_x;
        cap_y <= pt_y;
        cap_h <= pt_h;
        cap_r <= pt_r;
        ring  <= '0;
      end
      if (state == NEXT_RING && state_next == INIT) ring <= ring + 3'd1;
      if (ld) ring_v <= fade_v(int'(ring), V_STEP);
      if (ld || stp) slot <= '0;
      if (issue) begin
        slot <= slot + (sparse ? 3'd2 : 3'd1);
        if (visible) begin
          fig_x_o   <= px[XW-1:0];
          fig_y_o   <= py[YW-1:0];
          fig_h_o   <= cap_h;
          fig_s_o   <= 8'(SAT);
          fig_v_o   <= ring_v;
          fig_req_o <= 1'b1;
        end else begin
          fig_req_o <= 1'b0;
        end
      end else if (fig_req_o && fig_ack_i) begin
        fig_req_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fig_ring_gen.sv
// Self-checking bench for fig_ring_gen against a plain integer ring-drawing model.
module tb_fig_ring_gen;

  localparam int XW = 8, YW = 9, RW = 5, XMAX = 255, YMAX = 319;
  localparam int RINGS = 3, VSTEP = 64, SAT = 255;

  logic          clock;
  logic          reset;
  logic [XW-1:0] pt_x;
  logic [YW-1:0] pt_y;
  logic [7:0]    pt_h;
  logic [RW-1:0] pt_r;
  logic          pt_req_i;
  logic          pt_ack_o;
  logic [XW-1:0] fig_x_o;
  logic [YW-1:0] fig_y_o;
  logic [7:0]    fig_h_o, fig_s_o, fig_v_o;
  logic          fig_req_o;
  logic          fig_ack_i;
  logic          busy_o;

  int checks = 0;
  int errors = 0;
  logic [40:0] exp_q[$];

  fig_ring_gen #(
    .XW(XW), .YW(YW), .RW(RW), .X_MAX(XMAX), .Y_MAX(YMAX),
    .RINGS(RINGS), .V_STEP(VSTEP), .SAT(SAT)
  ) dut (
    .clock(clock), .reset(reset),
    .pt_x(pt_x), .pt_y(pt_y), .pt_h(pt_h), .pt_r(pt_r),
    .pt_req_i(pt_req_i), .pt_ack_o(pt_ack_o),
    .fig_x_o(fig_x_o), .fig_y_o(fig_y_o), .fig_h_o(fig_h_o),
    .fig_s_o(fig_s_o), .fig_v_o(fig_v_o),
    .fig_req_o(fig_req_o), .fig_ack_i(fig_ack_i), .busy_o(busy_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [40:0] pk(input int x, input int y, input int h, input int v);
    logic [7:0] xs, hs, vs, ss;
    logic [8:0] ys;
    int s;
    s  = SAT;
    xs = x[7:0]; ys = y[8:0]; hs = h[7:0]; vs = v[7:0]; ss = s[7:0];
    return {xs, ys, hs, ss, vs};
  endfunction

  function automatic void push_px(input int x, input int y, input int h, input int v);
    if (x >= 0 && x <= XMAX && y >= 0 && y <= YMAX) exp_q.push_back(pk(x, y, h, v));
  endfunction

  // Rings drawn with the textbook midpoint loop, one octant step per iteration
  function automatic void build(input int x0, input int y0, input int h, input int r);
    int ox[8];
    int oy[8];
    exp_q.delete();
    for (int k = 0; k < RINGS; k++) begin
      int rad, v, a, b, d;
      rad = r + k;
      if (rad > (1 << RW) - 1) break;
      v = 255 - k * VSTEP;
      if (v < 0) v = 0;
      if (rad == 0) begin
        push_px(x0, y0, h, v);
        continue;
      end
      a = rad; b = 0; d = 1 - rad;
      while (b <= a) begin
        ox = '{a, b, -b, -a, -a, -b, b, a};
        oy = '{b, a, a, b, -b, -a, -a, -b};
        for (int s = 0; s < 8; s++) begin
          if ((b == 0 || a == b) && (s % 2 == 1)) continue;
          push_px(x0 + ox[s], y0 + oy[s], h, v);
        end
        b++;
        if (d < 0) d += 2 * b + 1;
        else begin
          a--;
          d += 2 * (b - a) + 1;
        end
      end
    end
  endfunction

  task automatic send_point(input int x, input int y, input int h, input int r);
    bit got;
    got      = 0;
    pt_x     = x[XW-1:0];
    pt_y     = y[YW-1:0];
    pt_h     = h[7:0];
    pt_r     = r[RW-1:0];
    pt_req_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (pt_ack_o) begin
        got = 1;
        break;
      end
    end
    check("pt_ack_seen", 64'(got), 64'd1);
    check("ack_not_busy", 64'(busy_o), 64'd0);
    pt_req_i = 1'b0;
  endtask

  task automatic run_fig(input int x, input int y, input int h, input int r,
                         input bit bp, input bit check_lat);
    logic [40:0] prev, cur, want;
    bit held, finished, first;
    int cyc, lat;
    build(x, y, h, r);
    send_point(x, y, h, r);
    held = 0; finished = 0; first = 0; cyc = 0; lat = -1; prev = '0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) check("ack_one_pulse", 64'(pt_ack_o), 64'd0);
      cur = {fig_x_o, fig_y_o, fig_h_o, fig_s_o, fig_v_o};
      if (fig_req_o && !first) begin
        first = 1;
        lat   = cyc;
      end
      if (held) begin
        check("stall_req_held", 64'(fig_req_o), 64'd1);
        check("stall_stable", 64'(cur), 64'(prev));
      end
      fig_ack_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (fig_req_o && fig_ack_i) begin
        if (exp_q.size() == 0) check("extra_pixel", 64'(cur), 64'h1ffffffffff);
        else begin
          want = exp_q.pop_front();
          check("pixel", 64'(cur), 64'(want));
        end
      end
      held = fig_req_o && !fig_ack_i;
      prev = cur;
      if (!busy_o && !fig_req_o) begin
        finished = 1;
        break;
      end
    end
    fig_ack_i = 1'b1;
    check("fig_done_in_time", 64'(finished), 64'd1);
    check("missing_pixels", 64'(exp_q.size()), 64'd0);
    if (check_lat) check("first_req_latency", 64'(lat), 64'd3);
  endtask

  initial begin
    bit stray;
    reset     = 1'b0;
    pt_req_i  = 1'b0;
    pt_x      = '0;
    pt_y      = '0;
    pt_h      = '0;
    pt_r      = '0;
    fig_ack_i = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ack", 64'(pt_ack_o), 64'd0);
    check("rst_req", 64'(fig_req_o), 64'd0);
    check("rst_pixel", 64'({fig_x_o, fig_y_o, fig_h_o, fig_s_o, fig_v_o}), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    run_fig(10, 10, 100, 0, 0, 1);
    run_fig(100, 100, 7, 1, 0, 1);
    run_fig(100, 100, 50, 2, 0, 1);
    run_fig(0, 0, 9, 3, 0, 0);
    run_fig(255, 319, 33, 2, 0, 0);
    run_fig(200, 400, 1, 3, 0, 0);
    run_fig(128, 160, 77, 30, 0, 0);
    run_fig(100, 100, 50, 2, 1, 0);
    for (int n = 0; n < 6; n++)
      run_fig(int'($urandom_range(0, 255)), int'($urandom_range(0, 319)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 31)), 1, 0);

    // Abandon a figure mid-stream and make sure nothing leaks out afterwards
    send_point(100, 150, 200, 5);
    repeat (6) @(negedge clock);
    check("midfig_busy", 64'(busy_o), 64'd1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_req", 64'(fig_req_o), 64'd0);
    check("midrst_ack", 64'(pt_ack_o), 64'd0);
    check("midrst_pixel", 64'({fig_x_o, fig_y_o, fig_h_o, fig_s_o, fig_v_o}), 64'd0);
    stray = 0;
    repeat (30) begin
      @(negedge clock);
      if (fig_req_o || busy_o) stray = 1;
    end
    check("midrst_quiet", 64'(stray), 64'd0);
    run_fig(50, 60, 123, 4, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
